// File: rtl/shift_window_pkg.sv
// rtl/shift_window_pkg.sv - shared types and constants for the shift window controller
//
// Contents:
//   state_t     : controller states IDLE, FILL, RUN
//   OVR_CNT_W   : width of the overrun event counter
//   word_width  : bits needed for one sample word, $clog2(samples*osf)+1
package shift_window_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int OVR_CNT_W = 8;

  function automatic int word_width(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

endpackage

// File: rtl/shift_window_ctrl_if.sv
// rtl/shift_window_ctrl_if.sv - window handshake and status bundle
//
// Signals:
//   ShiftEn    : strobe that advances the downstream n-word shift register
//   FillCount  : words loaded since the last IDLE, saturating at n
//   WinValid   : a fresh full window is available
//   WinReady   : consumer accepts the window while WinValid is high
//   Overrun    : sticky flag, a window was overwritten unconsumed
//   OverrunCnt : saturating count of overwritten windows
// Modports: master (controller side), slave (consumer side).
interface shift_window_ctrl_if #(
  parameter int n = 3
) ();
  import shift_window_pkg::*;

  logic                    ShiftEn;
  logic [$clog2(n+1)-1:0]  FillCount;
  logic                    WinValid;
  logic                    WinReady;
  logic                    Overrun;
  logic [OVR_CNT_W-1:0]    OverrunCnt;

  modport master (
    output ShiftEn, FillCount, WinValid, Overrun, OverrunCnt,
    input  WinReady
  );

  modport slave (
    input  ShiftEn, FillCount, WinValid, Overrun, OverrunCnt,
    output WinReady
  );

endinterface

// File: rtl/osf_tick_gen.sv
// rtl/osf_tick_gen.sv - oversampling prescaler producing one tick every OSF cycles
//
// Ports:
//   Clk   : clock, rising edge
//   Reset : synchronous active-high reset
//   Clear : synchronous clear of the tick counter
//   Run   : counter advances while high; Tick is gated by it
//   Tick  : high in the cycle where the counter equals OSF-1
module osf_tick_gen #(
  parameter int OSF = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Run,
  output logic Tick
);

  localparam int            CW   = (OSF > 1) ? $clog2(OSF) : 1;
  localparam logic [CW-1:0] LAST = CW'(OSF - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      cnt_q <= '0;
    end else if (Run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign Tick = Run && (cnt_q == LAST);

endmodule

// File: rtl/shift_window_ctrl.sv
// rtl/shift_window_ctrl.sv - FSM sequencing fill and hand-off of an n-word sample window
//
// Ports:
//   Clk    : clock, rising edge
//   Reset  : synchronous active-high reset, overrides everything
//   Enable : run request; low returns the block to IDLE
//   win    : shift_window_ctrl_if.master (ShiftEn, FillCount, WinValid,
//            WinReady, Overrun, OverrunCnt)
// Build option: SHIFT_WINDOW_OVERRUN_EN enables overrun flag and counter;
// without it Overrun and OverrunCnt read as 0.
module shift_window_ctrl
  import shift_window_pkg::*;
#(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  parameter int n       = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Enable,
  shift_window_ctrl_if.master win
);

  localparam int             FCW       = $clog2(n + 1);
  localparam logic [FCW-1:0] FILL_MAX  = FCW'(n);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(n - 1);

  if (OSF < 2 || n < 1 || word_width(SAMPLES, OSF) > 32) begin : g_bad_params
    $error("shift_window_ctrl: illegal parameter set");
  end

  state_t         state_q, state_d;
  logic [FCW-1:0] fill_q, fill_d;
  logic           valid_q, valid_d;
  logic           active;
  logic           shift;

  assign active = (state_q != IDLE);

  // Clearing on !Enable makes the counter restart from 0 when we re-enter FILL.
  osf_tick_gen #(.OSF(OSF)) u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (!active || !Enable),
    .Run   (active),
    .Tick  (shift)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        fill_d  = '0;
        valid_d = 1'b0;
        if (Enable) state_d = FILL;
      end
      FILL: begin
        if (shift) begin
          fill_d = fill_q + FCW'(1);
          if (fill_q == FILL_LAST) begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        fill_d = FILL_MAX;
        // A new word always refreshes the window, even if it is being accepted now.
        if (shift) begin
          valid_d = 1'b1;
        end else if (valid_q && win.WinReady) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!Enable) begin
      state_d = IDLE;
      fill_d  = '0;
      valid_d = 1'b0;
    end
  end

  assign win.ShiftEn   = shift;
  assign win.FillCount = fill_q;
  assign win.WinValid  = valid_q;

`ifdef SHIFT_WINDOW_OVERRUN_EN
  logic                 ovr_q;
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (shift && valid_q && !win.WinReady) begin
      ovr_q <= 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_q <= ovr_cnt_q + OVR_CNT_W'(1);
    end
  end

  assign win.Overrun    = ovr_q;
  assign win.OverrunCnt = ovr_cnt_q;
`else
  assign win.Overrun    = 1'b0;
  assign win.OverrunCnt = '0;
`endif

endmodule
